ovl_fire_report_scheduler: RTL and testbench

//  Collects fire pulses from NUM_CHECKERS OVL checker instances (assert/assume) and keeps a

---
 rtl/ovl_fire_report_scheduler.sv | 90 +++++++++
 tb/tb_ovl_fire_report_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_fire_report_scheduler.sv
// ovl_fire_report_scheduler: per-checker saturating fire counters drained one at a time over a valid/ready report channel
module ovl_fire_report_scheduler #(
    parameter int NUM_CHECKERS = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int ID_WIDTH     = 2,
    parameter int FIXED_PRIO   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CHECKERS-1:0] fire,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [ID_WIDTH-1:0]     report_id,
    output logic [CNT_WIDTH-1:0]    report_count,
    output logic [NUM_CHECKERS-1:0] pending,
    output logic                    dropped
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_CHECKERS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_CHECKERS];
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d, id_q, id_d, win;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  dropped_q, dropped_d, found, grant;
    logic [NUM_CHECKERS-1:0] inc;
    int                    j;
    assign inc = {NUM_CHECKERS{enable}} & fire;
    for (genvar g = 0; g < NUM_CHECKERS; g++) begin : g_pend
        assign pending[g] = |cnt_q[g];
    end
    // search starts at the round-robin pointer, or at index 0 for fixed priority
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_CHECKERS; k++) begin
            j = (FIXED_PRIO != 0) ? k : (int'(ptr_q) + k) % NUM_CHECKERS;
            if (!found && pending[j]) begin
                win   = ID_WIDTH'(j);
                found = 1'b1;
            end
        end
    end
    assign grant = (state_q == IDLE) && found;
    always_comb begin
        dropped_d = dropped_q;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            cnt_d[i] = (grant && int'(win) == i) ? CNT_WIDTH'(inc[i]) :
                       (inc[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
            if (inc[i] && (&cnt_q[i]) && !(grant && int'(win) == i))
                dropped_d = 1'b1;
        end
    end
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = PRESENT;
            id_d    = win;
            count_d = cnt_q[win];
            ptr_d   = (int'(win) == NUM_CHECKERS - 1) ? '0 : win + 1'b1;
        end else if (state_q == PRESENT && report_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
            for (int i = 0; i < NUM_CHECKERS; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
            for (int i = 0; i < NUM_CHECKERS; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    assign report_valid = (state_q == PRESENT);
    assign report_id    = id_q;
    assign report_count = count_q;
    assign dropped      = dropped_q;
endmodule

// File: tb/tb_ovl_fire_report_scheduler.sv
// tb_ovl_fire_report_scheduler: scoreboard bench, round-robin 8-bit instance (a) beside fixed-priority 2-bit instance (b)
module tb_ovl_fire_report_scheduler;
    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b1, report_ready = 1'b0;
    logic [3:0] fire = '0;
    logic       va, vb, da, db;
    logic [1:0] ida, idb;
    logic [7:0] ca;
    logic [1:0] cb;
    logic [3:0] pa, pb;
    int cyc = 0, total = 0, bad = 0, t = 0;
    typedef struct {int id; int cnt; int cy;} exp_t;
    exp_t qa[$], qb[$];

    ovl_fire_report_scheduler #(.NUM_CHECKERS(4), .CNT_WIDTH(8), .ID_WIDTH(2), .FIXED_PRIO(0)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire), .report_valid(va),
        .report_ready(report_ready), .report_id(ida), .report_count(ca), .pending(pa), .dropped(da));
    ovl_fire_report_scheduler #(.NUM_CHECKERS(4), .CNT_WIDTH(2), .ID_WIDTH(2), .FIXED_PRIO(1)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire), .report_valid(vb),
        .report_ready(report_ready), .report_id(idb), .report_count(cb), .pending(pb), .dropped(db));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic void push2(int id, int cnt, int cy);
        qa.push_back('{id, cnt, cy});
        qb.push_back('{id, cnt, cy});
    endfunction

    logic hold_a = 1'b0, hold_b = 1'b0;
    int   hid_a, hcnt_a, hid_b, hcnt_b;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) hold_a = 1'b0;
        else begin
            if (hold_a) begin
                chk("a_hold_valid", int'(va), 1);
                chk("a_hold_id", int'(ida), hid_a);
                chk("a_hold_count", int'(ca), hcnt_a);
            end
            if (va && report_ready) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected_report: got id=%0d count=%0d expected none (cycle %0d)", ida, ca, cyc);
                end else begin
                    total--;
                    e = qa.pop_front();
                    chk("a_report_id", int'(ida), e.id);
                    chk("a_report_count", int'(ca), e.cnt);
                    chk("a_report_cycle", cyc, e.cy);
                end
            end
            hold_a = va && !report_ready;
            hid_a  = int'(ida);
            hcnt_a = int'(ca);
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) hold_b = 1'b0;
        else begin
            if (hold_b) begin
                chk("b_hold_valid", int'(vb), 1);
                chk("b_hold_id", int'(idb), hid_b);
                chk("b_hold_count", int'(cb), hcnt_b);
            end
            if (vb && report_ready) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected_report: got id=%0d count=%0d expected none (cycle %0d)", idb, cb, cyc);
                end else begin
                    total--;
                    e = qb.pop_front();
                    chk("b_report_id", int'(idb), e.id);
                    chk("b_report_count", int'(cb), e.cnt);
                    chk("b_report_cycle", cyc, e.cy);
                end
            end
            hold_b = vb && !report_ready;
            hid_b  = int'(idb);
            hcnt_b = int'(cb);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fire = '0;
        enable = 1'b1;
        report_ready = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic drain();
        report_ready = 1'b1;
        for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) tick(1);
        tick(4);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        #3;
        chk("rst_valid_a", int'(va), 0);
        chk("rst_pending_a", int'(pa), 0);
        chk("rst_dropped_b", int'(db), 0);
        do_reset();
        // single fire: pending for one cycle, report two cycles after the fire
        report_ready = 1'b1;
        t = cyc;
        fire = 4'b0100;
        push2(2, 1, t + 2);
        tick(1);
        fire = '0;
        chk("t1_pending_a", int'(pa), 4);
        chk("t1_pending_b", int'(pb), 4);
        chk("t1_valid_early", int'(va), 0);
        tick(1);
        chk("t1_pending_clear", int'(pa), 0);
        chk("t1_valid_a", int'(va), 1);
        tick(1);
        chk("t1_valid_after", int'(va), 0);
        drain();
        // three simultaneous fires drain in index order
        do_reset();
        report_ready = 1'b1;
        t = cyc;
        fire = 4'b1011;
        push2(0, 1, t + 2);
        push2(1, 1, t + 4);
        push2(3, 1, t + 6);
        tick(1);
        fire = '0;
        drain();
        // back-pressure: presented report stays stable while id1 accumulates
        do_reset();
        t = cyc;
        fire = 4'b0001;
        tick(1);
        fire = '0;
        tick(1);
        fire = 4'b0010;
        tick(3);
        fire = '0;
        chk("t3_valid", int'(va), 1);
        chk("t3_id", int'(ida), 0);
        chk("t3_count", int'(ca), 1);
        chk("t3_pending", int'(pa), 2);
        tick(1);
        report_ready = 1'b1;
        push2(0, 1, t + 6);
        push2(1, 3, t + 8);
        drain();
        // saturation: b (2-bit) loses a fire, a (8-bit) does not
        do_reset();
        t = cyc;
        fire = 4'b0001;
        tick(5);
        fire = '0;
        tick(1);
        chk("t4_dropped_a", int'(da), 0);
        chk("t4_dropped_b", int'(db), 1);
        chk("t4_snapshot_b", int'(cb), 1);
        chk("t4_pending_b", int'(pb), 1);
        report_ready = 1'b1;
        qa.push_back('{0, 1, t + 6});
        qa.push_back('{0, 4, t + 8});
        qb.push_back('{0, 1, t + 6});
        qb.push_back('{0, 3, t + 8});
        drain();
        chk("t4_dropped_sticky_b", int'(db), 1);
        chk("t4_dropped_a_after", int'(da), 0);
        chk("t4_pending_b_after", int'(pb), 0);
        // asynchronous reset while presenting
        do_reset();
        fire = 4'b0010;
        tick(1);
        fire = '0;
        tick(2);
        chk("t5_valid_before", int'(va), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_valid_a_async", int'(va), 0);
        chk("t5_valid_b_async", int'(vb), 0);
        chk("t5_id_a_async", int'(ida), 0);
        chk("t5_count_a_async", int'(ca), 0);
        tick(2);
        reset_n = 1'b1;
        report_ready = 1'b1;
        tick(10);
        chk("t5_no_stale", int'(va), 0);
        drain();
        // enable low: fires ignored, earlier count still drains
        do_reset();
        t = cyc;
        fire = 4'b0100;
        tick(1);
        enable = 1'b0;
        fire = 4'b1111;
        tick(4);
        chk("t6_pending_a", int'(pa), 0);
        chk("t6_pending_b", int'(pb), 0);
        chk("t6_id", int'(ida), 2);
        tick(6);
        fire = '0;
        enable = 1'b1;
        report_ready = 1'b1;
        push2(2, 1, t + 11);
        drain();
        chk("t6_dropped_a", int'(da), 0);
        chk("t6_pending_end", int'(pa), 0);
        // fire on the granted id in snapshot and handshake cycles
        do_reset();
        report_ready = 1'b1;
        t = cyc;
        fire = 4'b1000;
        push2(3, 1, t + 2);
        push2(3, 2, t + 4);
        tick(3);
        fire = '0;
        drain();
        // round-robin pointer vs fixed priority
        do_reset();
        report_ready = 1'b1;
        t = cyc;
        fire = 4'b0010;
        push2(1, 1, t + 2);
        tick(1);
        fire = '0;
        tick(2);
        fire = 4'b0110;
        qa.push_back('{2, 1, t + 5});
        qa.push_back('{1, 1, t + 7});
        qb.push_back('{1, 1, t + 5});
        qb.push_back('{2, 1, t + 7});
        tick(1);
        fire = '0;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
